// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: baudtick-paced start/data/stop serializer with a 1-deep holding register.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx_serializer #(
  parameter int DATABITS = 8,
  parameter int STOPBITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                baudtick,
  input  logic [DATABITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_busy,
  output logic                txd
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATABITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOPBITS - 1);

  state_t              state, state_n;
  logic [DATABITS-1:0] hold, hold_n;
  logic [DATABITS-1:0] shift, shift_n;
  logic                full, full_n;
  logic [2:0]          cnt, cnt_n;
  logic                txd_n;
  logic                busy_n;
  logic                accept;
`ifdef UART_TX_PARITY_EN
  logic                par, par_n;
`endif

  assign tx_ready = ~full;
  assign accept   = tx_valid & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hold    <= '0;
      shift   <= '0;
      full    <= 1'b0;
      cnt     <= '0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      shift   <= shift_n;
      full    <= full_n;
      cnt     <= cnt_n;
      txd     <= txd_n;
      tx_busy <= busy_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold;
    shift_n = shift;
    full_n  = full;
    cnt_n   = cnt;
    txd_n   = txd;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    if (accept) begin
      hold_n = tx_data;
      full_n = 1'b1;
    end
    if (baudtick) begin
      unique case (state)
        IDLE: begin
          if (full) begin
            state_n = START;
            shift_n = hold;
            full_n  = 1'b0;
            cnt_n   = '0;
            txd_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_n   = ^hold;
`endif
          end
        end
        START: begin
          state_n = DATA;
          txd_n   = shift[0];
          cnt_n   = '0;
        end
        DATA: begin
          if (cnt == LAST_BIT) begin
            cnt_n   = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = par;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            shift_n = shift >> 1;
            txd_n   = shift[1];
            cnt_n   = cnt + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_n = STOP;
          txd_n   = 1'b1;
        end
`endif
        STOP: begin
          if (cnt == LAST_STOP) begin
            // a held byte starts its frame with no idle gap
            if (full) begin
              state_n = START;
              shift_n = hold;
              full_n  = 1'b0;
              cnt_n   = '0;
              txd_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
              par_n   = ^hold;
`endif
            end else begin
              state_n = IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        default: begin
          state_n = IDLE;
          txd_n   = 1'b1;
        end
      endcase
    end
    busy_n = (state_n != IDLE) | full_n;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: frame decoder + scoreboard for the default build,
// plus a STOPBITS=2 instance checked bit by bit.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baudtick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, txd;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx_busy2, txd2;

  int   tests = 0;
  int   fails = 0;
  int   frames_done = 0;
  int   acc2 = 0;
  exp_t sb[$];
  vec_t vecs[12];

  uart_tx_serializer #(.DATABITS(8), .STOPBITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .baudtick(baudtick),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .txd(txd)
  );

  uart_tx_serializer #(.DATABITS(8), .STOPBITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baudtick(baudtick),
    .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_busy(tx_busy2), .txd(txd2)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (15) @(posedge clk);
      #1 baudtick = 1'b1;
      @(posedge clk);
      #1 baudtick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame decoder: samples txd just before each tick edge
  logic       mact = 1'b0;
  int         mcnt = 0;
  int         mgap = 0;
  int         fgap = 0;
  logic [7:0] mdata = 8'h00;
  logic       mpar = 1'b0;
  exp_t       me;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mact = 1'b0;
      mcnt = 0;
      mgap = 0;
    end else if (baudtick) begin
      if (!mact) begin
        if (txd == 1'b0) begin
          mact = 1'b1;
          mcnt = 0;
          fgap = mgap;
          mgap = 0;
        end else begin
          mgap++;
        end
      end else begin
        if (mcnt < DB) mdata[mcnt] = txd;
        else if (mcnt < DB + PB) mpar = txd;
        else check("stop_bit", {31'd0, txd}, 1);
        mcnt++;
        if (mcnt == DB + PB + 1) begin
          mact = 1'b0;
          mgap = 0;
          check("sb_has_entry", {31'd0, sb.size() != 0}, 1);
          if (sb.size() != 0) begin
            me = sb.pop_front();
            check("data", {24'd0, mdata}, {24'd0, me.data});
`ifdef UART_TX_PARITY_EN
            check("parity", {31'd0, mpar}, {31'd0, me.par});
`endif
            if (me.b2b) check("b2b_gap", fgap, 0);
          end
          frames_done++;
        end
      end
    end
  end

  always @(negedge clk)
    if (rst_n && tx_valid2 && tx_ready2) acc2++;

  task automatic wait_tick();
    @(negedge clk);
    while (!baudtick) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < 6000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("frames_timeout", {31'd0, frames_done >= n}, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input bit b2b);
    int   k = 0;
    exp_t e;
    @(negedge clk);
    while (!tx_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", {31'd0, tx_ready}, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    e.data = d;
    e.par  = p;
    e.b2b  = b2b;
    sb.push_back(e);
  endtask

  initial begin
    int   k;
    int   target;
    logic eb[$];

    vecs = '{
      '{8'h55, 1'b0}, '{8'hA3, 1'b0}, '{8'h0F, 1'b0}, '{8'h07, 1'b1},
      '{8'h03, 1'b0}, '{8'h81, 1'b0}, '{8'hF0, 1'b0}, '{8'hFF, 1'b0},
      '{8'h00, 1'b0}, '{8'h01, 1'b1}, '{8'h80, 1'b1}, '{8'hFE, 1'b1}
    };

    // reset held across several ticks
    repeat (40) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 1);
    check("rst_ready", {31'd0, tx_ready}, 1);
    check("rst_busy", {31'd0, tx_busy}, 0);
    check("rst_txd2", {31'd0, txd2}, 1);
    check("rst_ready2", {31'd0, tx_ready2}, 1);
    check("rst_busy2", {31'd0, tx_busy2}, 0);
    rst_n = 1'b1;

    // idle with ticks running
    for (int i = 0; i < 20; i++) begin
      repeat (50) @(negedge clk);
      check("idle_txd", {31'd0, txd}, 1);
      check("idle_ready", {31'd0, tx_ready}, 1);
      check("idle_busy", {31'd0, tx_busy}, 0);
    end

    // single frame and busy release
    target = frames_done + 1;
    send(8'h55, 1'b0, 1'b0);
    check("busy_after_accept", {31'd0, tx_busy}, 1);
    check("ready_after_accept", {31'd0, tx_ready}, 0);
    wait_frames(target);
    check("busy_in_last_stop", {31'd0, tx_busy}, 1);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_stop", {31'd0, tx_busy}, 0);
    check("ready_after_stop", {31'd0, tx_ready}, 1);
    check("txd_after_stop", {31'd0, txd}, 1);

    // back-to-back frames
    target = frames_done + 2;
    send(8'hA3, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b1);
    k = 0;
    while (!tx_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("ready_rise_at_start2", {30'd0, tx_ready, txd}, 32'h2);
    check("ready_low_duration", {31'd0, k > 100}, 1);
    wait_frames(target);

    // table of bytes, queued as fast as the holding register allows
    target = frames_done + 12;
    for (int i = 0; i < 12; i++) send(vecs[i].data, vecs[i].par, 1'b0);
    wait_frames(target);
    check("sb_drained", sb.size(), 0);

    // reset in the middle of a frame
    send(8'hF0, 1'b0, 1'b0);
    repeat (5) wait_tick();
    @(posedge clk);
    #1 check("mid_frame_low", {31'd0, txd}, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_txd", {31'd0, txd}, 1);
    check("async_rst_ready", {31'd0, tx_ready}, 1);
    check("async_rst_busy", {31'd0, tx_busy}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    target = frames_done + 1;
    send(8'h81, 1'b0, 1'b0);
    wait_frames(target);

    // two stop bits, valid held while the register is full
    eb.push_back(1'b0);
    for (int i = 0; i < 8; i++) eb.push_back(1'b0);
    if (PB == 1) eb.push_back(1'b0);
    eb.push_back(1'b1);
    eb.push_back(1'b1);
    eb.push_back(1'b0);
    for (int i = 0; i < 8; i++) eb.push_back(1'b1);
    if (PB == 1) eb.push_back(1'b0);
    eb.push_back(1'b1);
    eb.push_back(1'b1);
    eb.push_back(1'b1);
    @(negedge clk);
    tx_data2  = 8'h00;
    tx_valid2 = 1'b1;
    @(posedge clk);
    #1 tx_data2 = 8'hFF;
    wait_tick();
    for (int i = 0; i < eb.size(); i++) begin
      wait_tick();
      check($sformatf("sb2_bit%0d", i), {31'd0, txd2}, {31'd0, eb[i]});
      if (i == 4) tx_valid2 = 1'b0;
    end
    check("sb2_accepts", acc2, 2);
    @(posedge clk);
    @(negedge clk);
    check("sb2_busy_end", {31'd0, tx_busy2}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage directly downstream of the baud generator. Consumes its single-cycle baudtick pulse and serialises parallel bytes onto the txd line.
- Frame format: start bit, DATABITS LSB-first, optional parity bit, STOPBITS stop bits.
- A one-entry holding register lets the host queue the next byte while the current frame shifts, so frames go out back-to-back.

Parameters:
- DATABITS, 8, data bits per frame; legal range 5..8.
- STOPBITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; same clock as the baud generator.
- rst_n  input  1  asynchronous active-low reset.
- baudtick  input  1  one-clk-wide pulse per bit period, from the baud generator.
- tx_data  input  DATABITS  byte to send; sampled on accept.
- tx_valid  input  1  host offers tx_data.
- tx_ready  output  1  holding register empty. Accept = tx_valid & tx_ready on a clk edge.
- tx_busy  output  1  frame in progress or byte held.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset values (asynchronous, while rst_n=0): txd=1, tx_ready=1, tx_busy=0, state=IDLE, holding empty, bit counter=0.
- Reset mid-frame aborts the frame immediately and discards the held byte; txd returns to 1 asynchronously.
- Holding register:
  - Accept: latch tx_data, mark full; tx_ready falls the next cycle.
  - Drain: happens only on a baudtick that starts a frame; the register is empty the next cycle.
  - No accept and drain in the same cycle is possible, because tx_ready=0 whenever the register is full.
- State machine: IDLE, START, DATA, PARITY (feature only), STOP. All transitions happen only on clk edges where baudtick=1; between ticks, state and txd hold.
  - IDLE: txd=1. On baudtick with holding full → START; load shift register from holding; txd<=0.
  - START: on baudtick → DATA; txd<=shift[0]; bit counter<=0.
  - DATA: on each baudtick, shift right and increment counter; txd<=next bit. After bit DATABITS-1 has been held for one tick period, the next baudtick goes → PARITY if enabled, else → STOP. Either way txd<=parity or 1.
  - PARITY: on baudtick → STOP; txd<=1.
  - STOP: lasts STOPBITS tick periods. At the end of the last stop period:
    - holding full → START directly, with txd<=0 (back-to-back frames);
    - otherwise → IDLE.
- Bit timing:
  - Every bit lasts exactly one baudtick-to-baudtick interval.
  - The first bit starts on the first baudtick after the byte is held. Latency from accept to falling txd is 1 to (one bit period + 1) clk.
- tx_busy = (state != IDLE) | holding full; registered.
- txd is driven from a flop only; no combinational path from any input to txd.
- A baudtick asserted during reset has no effect.
- A baudtick in the same cycle as an accept into an empty holding register in IDLE does not start the frame; the next baudtick does.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is compiled in. The parity bit is sent after the data bits and is even parity, i.e. the XOR of the DATABITS data bits. Frame length = 1 + DATABITS + 1 + STOPBITS bits.
- Undefined: no PARITY state or parity logic; DATA goes straight to STOP. Frame length = 1 + DATABITS + STOPBITS bits.

Test Plan:
1. Reset, then baudtick every 16 clk with no tx_valid → txd=1, tx_ready=1, tx_busy=0 for 1000 clk.
2. Accept 0x55 (DATABITS=8, STOPBITS=1, no parity) → txd sequence per tick period 0,1,0,1,0,1,0,1,0,1. Then IDLE, tx_busy=0 one clk after the end of the stop period.
3. Accept 0xA3, then accept 0x0F as soon as tx_ready rises → second start bit immediately follows the first stop bit with no idle gap. tx_ready stays low from the second accept until the second frame's start tick.
4. With UART_TX_PARITY_EN: send 0x07 → parity bit 1; send 0x03 → parity bit 0. Frame is 11 bit periods.
5. Pull rst_n low mid-DATA of 0xF0 → txd=1 asynchronously, tx_ready=1, tx_busy=0. A post-reset accept of 0x81 transmits cleanly.
6. STOPBITS=2, accept 0x00 followed by 0xFF → 0x00 frame ends with two high bit periods before the next start bit; tx_valid held while tx_ready=0 is not accepted twice.
